pe_feeder: RTL and testbench

Initiator side of the PE data interface. It takes one layer-pass command from the GLB controller and drives a single PE through a fixed sequence: a one-cycle `set_info` configuration pulse, then the filter words, then ifmap and ipsum words streamed while opsum results are collected. All traffic uses the PE's enable/ready protocol. It sits between the GLB read/write ports and one PE instance in the PE array, and pulses `done` when the pass completes.

---
 rtl/pe_if_pkg.sv | 36 +++
 rtl/pe_chan_reg.sv | 41 ++++
 rtl/pe_feeder.sv | 183 ++++++++++++++++++
 tb/tb_pe_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_if_pkg.sv
// Shared types for the PE feeder: default field widths, FSM states, latched command layout.
// Channel indices let the per-channel fetch/send counters live in small arrays.
package pe_if_pkg;

  localparam int DEF_CONFIG_Q_BIT = 2;
  localparam int DEF_CONFIG_P_BIT = 5;
  localparam int DEF_CONFIG_U_BIT = 4;
  localparam int DEF_CONFIG_S_BIT = 4;
  localparam int DEF_CONFIG_F_BIT = 8;
  localparam int DEF_CONFIG_W_BIT = 8;
  localparam int DEF_CNT_W        = 16;

  localparam int CH_FILT  = 0;
  localparam int CH_IFMAP = 1;
  localparam int CH_IPSUM = 2;
  localparam int CH_OPSUM = 3;
  localparam int NUM_CH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FILT,
    STREAM,
    FIN
  } state_e;

  typedef struct packed {
    logic [DEF_CONFIG_Q_BIT-1:0] q;
    logic [DEF_CONFIG_P_BIT-1:0] p;
    logic [DEF_CONFIG_U_BIT-1:0] u;
    logic [DEF_CONFIG_S_BIT-1:0] s;
    logic [DEF_CONFIG_F_BIT-1:0] f;
    logic [DEF_CONFIG_W_BIT-1:0] w;
  } cmd_cfg_t;

endpackage

// File: rtl/pe_chan_reg.sv
// One-entry valid/ready holding register; 1-cycle load-to-valid latency.
// Holds data and valid until out_rdy; caller only loads when empty or draining.
module pe_chan_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (vld_q && out_rdy) vld_d = 1'b0;
    if (in_vld) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/pe_feeder.sv
// Drives one PE through config pulse, filter load, then concurrent ifmap/ipsum/opsum streaming.
// 1-cycle register on every channel; sources stall when a register is full and the PE is not accepting.
module pe_feeder #(
  parameter int IFMAP_DATA_SIZE  = 8,
  parameter int FILTER_DATA_SIZE = 8,
  parameter int FILTER_NUM       = 4,
  parameter int PSUM_DATA_SIZE   = 8,
  parameter int CONFIG_Q_BIT     = pe_if_pkg::DEF_CONFIG_Q_BIT,
  parameter int CONFIG_P_BIT     = pe_if_pkg::DEF_CONFIG_P_BIT,
  parameter int CONFIG_U_BIT     = pe_if_pkg::DEF_CONFIG_U_BIT,
  parameter int CONFIG_S_BIT     = pe_if_pkg::DEF_CONFIG_S_BIT,
  parameter int CONFIG_F_BIT     = pe_if_pkg::DEF_CONFIG_F_BIT,
  parameter int CONFIG_W_BIT     = pe_if_pkg::DEF_CONFIG_W_BIT,
  parameter int CNT_W            = pe_if_pkg::DEF_CNT_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [CONFIG_Q_BIT-1:0]                cmd_q,
  input  logic [CONFIG_P_BIT-1:0]                cmd_p,
  input  logic [CONFIG_U_BIT-1:0]                cmd_U,
  input  logic [CONFIG_S_BIT-1:0]                cmd_S,
  input  logic [CONFIG_F_BIT-1:0]                cmd_F,
  input  logic [CONFIG_W_BIT-1:0]                cmd_W,
  input  logic [CNT_W-1:0]                       cmd_filter_cnt,
  input  logic [CNT_W-1:0]                       cmd_ifmap_cnt,
  input  logic [CNT_W-1:0]                       cmd_ipsum_cnt,
  input  logic [CNT_W-1:0]                       cmd_opsum_cnt,
  input  logic                                   src_filter_valid,
  output logic                                   src_filter_ready,
  input  logic [FILTER_NUM*FILTER_DATA_SIZE-1:0] src_filter_data,
  input  logic                                   src_ifmap_valid,
  output logic                                   src_ifmap_ready,
  input  logic [IFMAP_DATA_SIZE-1:0]             src_ifmap_data,
  input  logic                                   src_ipsum_valid,
  output logic                                   src_ipsum_ready,
  input  logic [PSUM_DATA_SIZE-1:0]              src_ipsum_data,
  output logic                                   snk_opsum_valid,
  input  logic                                   snk_opsum_ready,
  output logic [PSUM_DATA_SIZE-1:0]              snk_opsum_data,
  output logic [FILTER_NUM*FILTER_DATA_SIZE-1:0] filter,
  output logic                                   filter_enable,
  input  logic                                   filter_ready,
  output logic [IFMAP_DATA_SIZE-1:0]             ifmap,
  output logic                                   ifmap_enable,
  input  logic                                   ifmap_ready,
  output logic [PSUM_DATA_SIZE-1:0]              ipsum,
  output logic                                   ipsum_enable,
  input  logic                                   ipsum_ready,
  input  logic [PSUM_DATA_SIZE-1:0]              opsum,
  input  logic                                   opsum_enable,
  output logic                                   opsum_ready,
  output logic                                   set_info,
  output logic [CONFIG_Q_BIT-1:0]                config_q,
  output logic [CONFIG_P_BIT-1:0]                config_p,
  output logic [CONFIG_U_BIT-1:0]                config_U,
  output logic [CONFIG_S_BIT-1:0]                config_S,
  output logic [CONFIG_F_BIT-1:0]                config_F,
  output logic [CONFIG_W_BIT-1:0]                config_W,
  output logic                                   busy,
  output logic                                   done
);

  import pe_if_pkg::*;

  localparam int FW = FILTER_NUM * FILTER_DATA_SIZE;

  state_e           state_q, state_d;
  cmd_cfg_t         cfg_q, cfg_d;
  logic [CNT_W-1:0] fetch_q [NUM_CH];
  logic [CNT_W-1:0] fetch_d [NUM_CH];
  logic [CNT_W-1:0] send_q  [NUM_CH];
  logic [CNT_W-1:0] send_d  [NUM_CH];
  logic [NUM_CH-1:0] active, push, pop;
  logic             cmd_hs;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign busy      = ~cmd_ready;
  assign set_info  = (state_q == CFG);
  assign done      = (state_q == FIN);

  assign config_q = cfg_q.q;
  assign config_p = cfg_q.p;
  assign config_U = cfg_q.u;
  assign config_S = cfg_q.s;
  assign config_F = cfg_q.f;
  assign config_W = cfg_q.w;

  assign active[CH_FILT]  = (state_q == FILT);
  assign active[CH_IFMAP] = (state_q == STREAM);
  assign active[CH_IPSUM] = (state_q == STREAM);
  assign active[CH_OPSUM] = (state_q == STREAM);

  // A fetch may land in the register on the same edge the PE drains it.
  assign src_filter_ready = active[CH_FILT]  & (fetch_q[CH_FILT]  != '0) & (~filter_enable | filter_ready);
  assign src_ifmap_ready  = active[CH_IFMAP] & (fetch_q[CH_IFMAP] != '0) & (~ifmap_enable  | ifmap_ready);
  assign src_ipsum_ready  = active[CH_IPSUM] & (fetch_q[CH_IPSUM] != '0) & (~ipsum_enable  | ipsum_ready);
  assign opsum_ready      = active[CH_OPSUM] & (fetch_q[CH_OPSUM] != '0) & (~snk_opsum_valid | snk_opsum_ready);

  assign push = {opsum_enable & opsum_ready, src_ipsum_valid & src_ipsum_ready,
                 src_ifmap_valid & src_ifmap_ready, src_filter_valid & src_filter_ready};
  assign pop  = {snk_opsum_valid & snk_opsum_ready, ipsum_enable & ipsum_ready,
                 ifmap_enable & ifmap_ready, filter_enable & filter_ready};

  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_CH; i++) begin
      fetch_d[i] = fetch_q[i];
      send_d[i]  = send_q[i];
      if (push[i]) fetch_d[i] = fetch_q[i] - CNT_W'(1);
      if (pop[i])  send_d[i]  = send_q[i] - CNT_W'(1);
    end
    if (cmd_hs) begin
      cfg_d.q = cmd_q;
      cfg_d.p = cmd_p;
      cfg_d.u = cmd_U;
      cfg_d.s = cmd_S;
      cfg_d.f = cmd_F;
      cfg_d.w = cmd_W;
      fetch_d[CH_FILT]  = cmd_filter_cnt;
      fetch_d[CH_IFMAP] = cmd_ifmap_cnt;
      fetch_d[CH_IPSUM] = cmd_ipsum_cnt;
      fetch_d[CH_OPSUM] = cmd_opsum_cnt;
      send_d[CH_FILT]   = cmd_filter_cnt;
      send_d[CH_IFMAP]  = cmd_ifmap_cnt;
      send_d[CH_IPSUM]  = cmd_ipsum_cnt;
      send_d[CH_OPSUM]  = cmd_opsum_cnt;
    end
  end

  // Phases end on the send side: every fetched word must be accepted downstream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs) state_d = CFG;
      CFG:     state_d = FILT;
      FILT:    if (send_q[CH_FILT] == '0) state_d = STREAM;
      STREAM:  if ((send_q[CH_IFMAP] == '0) && (send_q[CH_IPSUM] == '0) &&
                   (send_q[CH_OPSUM] == '0)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        fetch_q[i] <= '0;
        send_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      fetch_q <= fetch_d;
      send_q  <= send_d;
    end
  end

  pe_chan_reg #(.W(FW)) u_filter (
    .clk(clk), .rst(rst), .in_vld(push[CH_FILT]), .in_dat(src_filter_data),
    .out_vld(filter_enable), .out_rdy(filter_ready), .out_dat(filter)
  );

  pe_chan_reg #(.W(IFMAP_DATA_SIZE)) u_ifmap (
    .clk(clk), .rst(rst), .in_vld(push[CH_IFMAP]), .in_dat(src_ifmap_data),
    .out_vld(ifmap_enable), .out_rdy(ifmap_ready), .out_dat(ifmap)
  );

  pe_chan_reg #(.W(PSUM_DATA_SIZE)) u_ipsum (
    .clk(clk), .rst(rst), .in_vld(push[CH_IPSUM]), .in_dat(src_ipsum_data),
    .out_vld(ipsum_enable), .out_rdy(ipsum_ready), .out_dat(ipsum)
  );

  pe_chan_reg #(.W(PSUM_DATA_SIZE)) u_opsum (
    .clk(clk), .rst(rst), .in_vld(push[CH_OPSUM]), .in_dat(opsum),
    .out_vld(snk_opsum_valid), .out_rdy(snk_opsum_ready), .out_dat(snk_opsum_data)
  );

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized bench for pe_feeder: sources/PE/sink models with ordered-stream and timing expectations.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_q;
  logic [4:0]  cmd_p;
  logic [3:0]  cmd_U, cmd_S;
  logic [7:0]  cmd_F, cmd_W;
  logic [15:0] cmd_filter_cnt, cmd_ifmap_cnt, cmd_ipsum_cnt, cmd_opsum_cnt;
  logic        src_filter_valid, src_filter_ready;
  logic [31:0] src_filter_data;
  logic        src_ifmap_valid, src_ifmap_ready;
  logic [7:0]  src_ifmap_data;
  logic        src_ipsum_valid, src_ipsum_ready;
  logic [7:0]  src_ipsum_data;
  logic        snk_opsum_valid, snk_opsum_ready;
  logic [7:0]  snk_opsum_data;
  logic [31:0] filter;
  logic        filter_enable, filter_ready;
  logic [7:0]  ifmap;
  logic        ifmap_enable, ifmap_ready;
  logic [7:0]  ipsum;
  logic        ipsum_enable, ipsum_ready;
  logic [7:0]  opsum;
  logic        opsum_enable, opsum_ready;
  logic        set_info;
  logic [1:0]  config_q;
  logic [4:0]  config_p;
  logic [3:0]  config_U, config_S;
  logic [7:0]  config_F, config_W;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] fdat [64];
  logic [31:0] idat [64];
  logic [31:0] pdat [64];
  logic [31:0] odat [64];

  always #5 clk = ~clk;

  pe_feeder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_q(cmd_q), .cmd_p(cmd_p), .cmd_U(cmd_U), .cmd_S(cmd_S), .cmd_F(cmd_F), .cmd_W(cmd_W),
    .cmd_filter_cnt(cmd_filter_cnt), .cmd_ifmap_cnt(cmd_ifmap_cnt),
    .cmd_ipsum_cnt(cmd_ipsum_cnt), .cmd_opsum_cnt(cmd_opsum_cnt),
    .src_filter_valid(src_filter_valid), .src_filter_ready(src_filter_ready), .src_filter_data(src_filter_data),
    .src_ifmap_valid(src_ifmap_valid), .src_ifmap_ready(src_ifmap_ready), .src_ifmap_data(src_ifmap_data),
    .src_ipsum_valid(src_ipsum_valid), .src_ipsum_ready(src_ipsum_ready), .src_ipsum_data(src_ipsum_data),
    .snk_opsum_valid(snk_opsum_valid), .snk_opsum_ready(snk_opsum_ready), .snk_opsum_data(snk_opsum_data),
    .filter(filter), .filter_enable(filter_enable), .filter_ready(filter_ready),
    .ifmap(ifmap), .ifmap_enable(ifmap_enable), .ifmap_ready(ifmap_ready),
    .ipsum(ipsum), .ipsum_enable(ipsum_enable), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_enable(opsum_enable), .opsum_ready(opsum_ready),
    .set_info(set_info),
    .config_q(config_q), .config_p(config_p), .config_U(config_U),
    .config_S(config_S), .config_F(config_F), .config_W(config_W),
    .busy(busy), .done(done)
  );

  task automatic expect_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // PE-side receiver: accepted words must match the source order, and a
  // word left waiting must reappear unchanged on the next cycle.
  task automatic pe_mon(input logic en, input logic rdy, input logic [31:0] dat,
                        input logic [31:0] exp_dat, input int n, input int cyc,
                        inout int got, inout int last, inout logic hold,
                        inout logic [31:0] hold_dat, inout int hviol, inout int derr);
    if (hold && (!en || dat != hold_dat)) hviol++;
    hold = 1'b0;
    if (en && rdy) begin
      if (got >= n || dat != exp_dat) derr++;
      got++;
      last = cyc;
    end else if (en) begin
      hold     = 1'b1;
      hold_dat = dat;
    end
  endtask

  // mode: 0 random handshakes, 1 everything ready, 2 ifmap_ready toggles, 3 sink stalls 3 cycles
  task automatic run_cmd(input logic [1:0] q, input logic [4:0] p, input logic [3:0] u,
                         input logic [3:0] s, input logic [7:0] f, input logic [7:0] w,
                         input int nf, input int ni, input int nip, input int nop,
                         input int mode, input int rst_at);
    int t_cmd = -1, cyc = 0;
    int fc = 0, ic = 0, pc = 0, fr = 0, ir = 0, pr = 0, og = 0, sc = 0;
    int last_f = -1, last_i = -1, last_p = -1, last_s = -1, first_fen = -1;
    int si_cnt = 0, si_cyc = -1, done_cnt = 0, done_cyc = -1;
    int hviol = 0, derr = 0, order_viol = 0, rdy_viol = 0;
    int stall_left = 3, rst_phase = 0, ps, pp, po, pk, lst;
    logic hf = 0, hi = 0, hp = 0, op_hold = 0;
    logic [31:0] hfd = 0, hid = 0, hpd = 0;
    logic [30:0] cfg_exp, cfg_seen = '0;
    cfg_exp = {q, p, u, s, f, w};
    ps = (mode == 0) ? 70 : 100;
    pp = ps; po = ps; pk = ps;
    for (int k = 0; k < 64; k++) begin
      fdat[k] = $urandom;
      idat[k] = (mode == 2) ? 32'(k + 1) : ($urandom & 32'hff);
      pdat[k] = $urandom & 32'hff;
      odat[k] = $urandom & 32'hff;
    end
    while (cyc < 3000) begin
      @(negedge clk);
      rst       = (rst_phase == 1) ? 1'b0 : 1'b1;
      cmd_valid = (t_cmd < 0);
      if (t_cmd < 0) begin
        cmd_q = q; cmd_p = p; cmd_U = u; cmd_S = s; cmd_F = f; cmd_W = w;
        cmd_filter_cnt = 16'(nf); cmd_ifmap_cnt = 16'(ni);
        cmd_ipsum_cnt = 16'(nip); cmd_opsum_cnt = 16'(nop);
      end else begin
        cmd_q = 2'($urandom); cmd_p = 5'($urandom); cmd_U = 4'($urandom);
        cmd_S = 4'($urandom); cmd_F = 8'($urandom); cmd_W = 8'($urandom);
        cmd_filter_cnt = 16'($urandom); cmd_ifmap_cnt = 16'($urandom);
        cmd_ipsum_cnt = 16'($urandom); cmd_opsum_cnt = 16'($urandom);
      end
      src_filter_valid = rnd(ps);
      src_filter_data  = (fc < 64) ? fdat[fc] : 32'h0;
      src_ifmap_valid  = rnd(ps);
      src_ifmap_data   = (ic < 64) ? idat[ic][7:0] : 8'h0;
      src_ipsum_valid  = rnd(ps);
      src_ipsum_data   = (pc < 64) ? pdat[pc][7:0] : 8'h0;
      filter_ready     = rnd(pp);
      ifmap_ready      = (mode == 2) ? (cyc % 2 == 0) : rnd(pp);
      ipsum_ready      = rnd(pp);
      opsum_enable     = op_hold | rnd(po);
      opsum            = (og < 64) ? odat[og][7:0] : 8'h0;
      if (mode == 3 && snk_opsum_valid && stall_left > 0) begin
        snk_opsum_ready = 1'b0;
        stall_left--;
      end else begin
        snk_opsum_ready = rnd(pk);
      end
      #1;
      if (rst_phase == 2) begin
        expect_eq("mrst_cmd_ready", cmd_ready, 1);
        expect_eq("mrst_busy", busy, 0);
        expect_eq("mrst_enables", {filter_enable, ifmap_enable, ipsum_enable, snk_opsum_valid,
                                   opsum_ready, src_ifmap_ready, set_info, done}, 0);
        return;
      end
      if (cmd_valid && cmd_ready) t_cmd = cyc;
      if (set_info) begin
        si_cnt++;
        si_cyc   = cyc;
        cfg_seen = {config_q, config_p, config_U, config_S, config_F, config_W};
      end
      if (fr < nf && (ifmap_enable || ipsum_enable || src_ifmap_ready || src_ipsum_ready || opsum_ready))
        order_viol++;
      if ((src_filter_ready && filter_enable && !filter_ready) ||
          (src_ifmap_ready && ifmap_enable && !ifmap_ready) ||
          (src_ipsum_ready && ipsum_enable && !ipsum_ready) ||
          (opsum_ready && snk_opsum_valid && !snk_opsum_ready))
        rdy_viol++;
      if (src_filter_valid && src_filter_ready) fc++;
      if (src_ifmap_valid && src_ifmap_ready) ic++;
      if (src_ipsum_valid && src_ipsum_ready) pc++;
      if (filter_enable && first_fen < 0) first_fen = cyc;
      pe_mon(filter_enable, filter_ready, filter, (fr < 64) ? fdat[fr] : 32'h0, nf, cyc,
             fr, last_f, hf, hfd, hviol, derr);
      pe_mon(ifmap_enable, ifmap_ready, {24'h0, ifmap}, (ir < 64) ? idat[ir] : 32'h0, ni, cyc,
             ir, last_i, hi, hid, hviol, derr);
      pe_mon(ipsum_enable, ipsum_ready, {24'h0, ipsum}, (pr < 64) ? pdat[pr] : 32'h0, nip, cyc,
             pr, last_p, hp, hpd, hviol, derr);
      op_hold = opsum_enable && !opsum_ready;
      if (opsum_enable && opsum_ready) og++;
      if (snk_opsum_valid && snk_opsum_ready) begin
        if (sc >= nop || sc >= 64 || {24'h0, snk_opsum_data} != odat[sc]) derr++;
        sc++;
        last_s = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rst_phase == 1) rst_phase = 2;
      else if (rst_phase == 0 && rst_at > 0 && ir == rst_at) rst_phase = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      cyc++;
    end
    expect_eq("done_count", done_cnt, 1);
    expect_eq("set_info_count", si_cnt, 1);
    expect_eq("set_info_lat", si_cyc - t_cmd, 1);
    expect_eq("config_at_set_info", cfg_seen, cfg_exp);
    expect_eq("config_held", {config_q, config_p, config_U, config_S, config_F, config_W}, cfg_exp);
    expect_eq("filter_fetch", fc, nf);
    expect_eq("filter_recv", fr, nf);
    expect_eq("ifmap_fetch", ic, ni);
    expect_eq("ifmap_recv", ir, ni);
    expect_eq("ipsum_fetch", pc, nip);
    expect_eq("ipsum_recv", pr, nip);
    expect_eq("opsum_take", og, nop);
    expect_eq("opsum_sink", sc, nop);
    expect_eq("data_errors", derr, 0);
    expect_eq("hold_violations", hviol, 0);
    expect_eq("phase_order", order_viol, 0);
    expect_eq("ready_rule", rdy_viol, 0);
    expect_eq("idle_after_done", {cmd_ready, busy}, 2);
    lst = last_i;
    if (last_p > lst) lst = last_p;
    if (last_s > lst) lst = last_s;
    if (ni + nip + nop > 0) expect_eq("done_after_last", done_cyc - lst, 2);
    else if (nf == 0) expect_eq("done_all_zero", done_cyc - t_cmd, 4);
    if (mode == 1 && nf > 0) begin
      expect_eq("filter_first_enable", first_fen - t_cmd, 3);
      expect_eq("filter_back_to_back", last_f - first_fen, nf - 1);
    end
    if (mode == 3) expect_eq("sink_stall_applied", stall_left, 0);
  endtask

  initial begin
    int nf, ni, nip, nop;
    rst = 1'b0;
    cmd_valid = 0; cmd_q = 0; cmd_p = 0; cmd_U = 0; cmd_S = 0; cmd_F = 0; cmd_W = 0;
    cmd_filter_cnt = 0; cmd_ifmap_cnt = 0; cmd_ipsum_cnt = 0; cmd_opsum_cnt = 0;
    src_filter_valid = 0; src_filter_data = 0; src_ifmap_valid = 0; src_ifmap_data = 0;
    src_ipsum_valid = 0; src_ipsum_data = 0; snk_opsum_ready = 0;
    filter_ready = 0; ifmap_ready = 0; ipsum_ready = 0; opsum = 0; opsum_enable = 0;
    repeat (3) @(negedge clk);
    #1;
    expect_eq("reset_cmd_ready", cmd_ready, 1);
    expect_eq("reset_ctl", {filter_enable, ifmap_enable, ipsum_enable, src_filter_ready,
                            src_ifmap_ready, src_ipsum_ready, snk_opsum_valid, opsum_ready,
                            set_info, busy, done}, 0);
    expect_eq("reset_cfg", {config_q, config_p, config_U, config_S, config_F, config_W}, 0);
    expect_eq("reset_data", {filter, ifmap, ipsum, snk_opsum_data}, 0);
    rst = 1'b1;

    run_cmd(2'd1, 5'd3, 4'd1, 4'd3, 8'd32, 8'd34, 4, 2, 2, 2, 1, 0);
    run_cmd(2'd2, 5'd7, 4'd2, 4'd1, 8'd16, 8'd18, 1, 8, 0, 0, 2, 0);
    run_cmd(2'd0, 5'd1, 4'd1, 4'd1, 8'd8, 8'd8, 0, 0, 0, 5, 3, 0);
    run_cmd(2'd3, 5'd31, 4'd15, 4'd15, 8'd255, 8'd255, 0, 0, 0, 0, 1, 0);
    run_cmd(2'd1, 5'd2, 4'd3, 4'd2, 8'd10, 8'd12, 2, 8, 3, 3, 1, 3);
    run_cmd(2'd2, 5'd4, 4'd2, 4'd2, 8'd20, 8'd22, 3, 4, 2, 3, 1, 0);
    for (int r = 0; r < 20; r++) begin
      nf  = int'($urandom_range(12));
      ni  = int'($urandom_range(12));
      nip = int'($urandom_range(12));
      nop = int'($urandom_range(12));
      if (ni + nip + nop == 0) ni = 1;
      run_cmd(2'($urandom), 5'($urandom), 4'($urandom), 4'($urandom), 8'($urandom),
              8'($urandom), nf, ni, nip, nop, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
